// File: rtl/data_cache_ctrl_if.sv
// Bundles the MEM-stage request bus and the SRAM-controller bus of the data cache.
// The cache takes the slave view; the pipeline/SRAM environment takes the master view.
// Pure wiring, no state.
interface data_cache_ctrl_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  mem_r_en, mem_w_en, address, wdata, sram_rdata, sram_ready,
        output rdata, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
    );

    modport master (
        output mem_r_en, mem_w_en, address, wdata, sram_rdata, sram_ready,
        input  rdata, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
    );
endinterface

// File: rtl/data_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate data cache, one word per line.
// Read hit: same cycle. Read miss / any write: 1 decision cycle + SRAM controller transaction.
// ready=0 freezes the pipeline until the SRAM controller reports sram_ready on its final cycle.
module data_cache_ctrl #(
    parameter int INDEX_BITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    data_cache_ctrl_if.slave  bus
);
    localparam int SETS     = 2 ** INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

    state_t state, state_next;

    logic [SETS-1:0]     valid0, valid1, lru;
    logic [TAG_BITS-1:0] tag0  [SETS];
    logic [TAG_BITS-1:0] tag1  [SETS];
    logic [31:0]         data0 [SETS];
    logic [31:0]         data1 [SETS];

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit0, hit1, hit;
    logic                  write_req, read_req;
    logic                  fill_way;
    logic                  unused_addr_lsb;

    assign index           = bus.address[INDEX_BITS+1:2];
    assign tag             = bus.address[31:INDEX_BITS+2];
    assign unused_addr_lsb = ^bus.address[1:0];

    // A tag is only ever installed in one way of a set, so hit0 and hit1 are exclusive.
    assign hit0 = valid0[index] && (tag0[index] == tag);
    assign hit1 = valid1[index] && (tag1[index] == tag);
    assign hit  = hit0 || hit1;

    // A store wins over a simultaneous load.
    assign write_req = bus.mem_w_en;
    assign read_req  = bus.mem_r_en && !bus.mem_w_en;

    // Prefer an empty way; otherwise evict the way the lru bit points at.
    assign fill_way = !valid0[index] ? 1'b0 :
                      !valid1[index] ? 1'b1 : lru[index];

    assign bus.sram_address = bus.address;
    assign bus.sram_wdata   = bus.wdata;

    // State register; reset aborts any SRAM transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; SRAM enables depend on state only.
    always_comb begin
        state_next     = state;
        bus.ready      = 1'b1;
        bus.rdata      = 32'h0;
        bus.sram_rd_en = 1'b0;
        bus.sram_wr_en = 1'b0;
        case (state)
            IDLE: begin
                if (write_req) begin
                    bus.ready  = 1'b0;
                    state_next = WR;
                end else if (read_req) begin
                    if (hit) begin
                        bus.rdata = hit1 ? data1[index] : data0[index];
                    end else begin
                        bus.ready  = 1'b0;
                        state_next = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                bus.sram_rd_en = 1'b1;
                bus.ready      = bus.sram_ready;
                if (bus.sram_ready) begin
                    bus.rdata  = bus.sram_rdata;
                    state_next = IDLE;
                end
            end
            WR: begin
                bus.sram_wr_en = 1'b1;
                bus.ready      = bus.sram_ready;
                if (bus.sram_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Valid and replacement bits: cleared on reset, updated on hits, fills and write hits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_req && hit) begin
                        lru[index] <= ~hit1;
                    end
                end
                RD_MISS: begin
                    if (bus.sram_ready) begin
                        if (fill_way) begin
                            valid1[index] <= 1'b1;
                        end else begin
                            valid0[index] <= 1'b1;
                        end
                        lru[index] <= ~fill_way;
                    end
                end
                WR: begin
                    if (bus.sram_ready && hit) begin
                        lru[index] <= ~hit1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data arrays: written on miss fill and on write hit; contents meaningless until valid.
    always_ff @(posedge clk) begin
        if (state == RD_MISS && bus.sram_ready) begin
            if (fill_way) begin
                tag1[index]  <= tag;
                data1[index] <= bus.sram_rdata;
            end else begin
                tag0[index]  <= tag;
                data0[index] <= bus.sram_rdata;
            end
        end else if (state == WR && bus.sram_ready && hit) begin
            if (hit1) begin
                data1[index] <= bus.wdata;
            end else begin
                data0[index] <= bus.wdata;
            end
        end
    end
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Random and directed traffic against a recency-list cache model with a scoreboard monitor.
// Expected hit/miss, data, SRAM enable usage and stall length are queued at issue time.
// A small SRAM controller model with per-transaction random latency drives sram_ready.
module tb_data_cache_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    data_cache_ctrl_if bus ();

    data_cache_ctrl #(.INDEX_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        is_wr;
        logic        access;
        logic [31:0] rdata;
        logic [7:0]  stall;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endfunction

    // ---------------- SRAM controller model ----------------
    logic [31:0] sram_mem [1024];
    int          sram_lat = 1;
    int          cnt;

    always_comb begin
        bus.sram_ready = (bus.sram_rd_en || bus.sram_wr_en) && (cnt >= sram_lat - 1);
        bus.sram_rdata = bus.sram_rd_en ? sram_mem[bus.sram_address[11:2]] : 32'hBAD0_BAD0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 0;
        end else begin
            if ((bus.sram_rd_en || bus.sram_wr_en) && !bus.sram_ready) cnt <= cnt + 1;
            else cnt <= 0;
            if (bus.sram_wr_en && bus.sram_ready) sram_mem[bus.sram_address[11:2]] <= bus.sram_wdata;
        end
    end

    // ---------------- reference model: per-set recency list of up to two tags ----------------
    logic [31:0] ref_mem [1024];
    logic [23:0] mru_tag [64];
    logic [23:0] lru_tag [64];
    int          fill    [64];

    function automatic bit model_touch(logic [31:0] a, bit alloc);
        int          s = int'(a[7:2]);
        logic [23:0] t = a[31:8];
        if (fill[s] >= 1 && mru_tag[s] == t) return 1'b1;
        if (fill[s] == 2 && lru_tag[s] == t) begin
            lru_tag[s] = mru_tag[s];
            mru_tag[s] = t;
            return 1'b1;
        end
        if (alloc) begin
            lru_tag[s] = mru_tag[s];
            mru_tag[s] = t;
            if (fill[s] < 2) fill[s]++;
        end
        return 1'b0;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 64; i++) fill[i] = 0;
    endfunction

    // ---------------- monitor ----------------
    logic rd_now, wr_now;
    logic saw_rd, saw_wr;
    int   stall_now, stall;
    exp_t e;

    always @(negedge clk) begin
        if (rst) begin
            saw_rd <= 1'b0;
            saw_wr <= 1'b0;
            stall  <= 0;
        end else begin
            rd_now    = saw_rd | bus.sram_rd_en;
            wr_now    = saw_wr | bus.sram_wr_en;
            stall_now = stall;
            if (bus.sram_rd_en && bus.sram_wr_en) chk("both_enables", 32'd1, 32'd0);
            if (bus.sram_rd_en || bus.sram_wr_en) begin
                chk("sram_address", bus.sram_address, bus.address);
                chk("sram_wdata", bus.sram_wdata, bus.wdata);
            end
            if (!bus.mem_r_en && !bus.mem_w_en) begin
                chk("idle_ready", {31'd0, bus.ready}, 32'd1);
                chk("idle_rdata", bus.rdata, 32'd0);
                chk("idle_sram_en", {30'd0, bus.sram_rd_en, bus.sram_wr_en}, 32'd0);
            end else if (!bus.ready) begin
                chk("stall_rdata", bus.rdata, 32'd0);
                stall_now = stall_now + 1;
            end else begin
                if (q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rdata", bus.rdata, e.rdata);
                    chk("sram_rd_used", {31'd0, rd_now}, {31'd0, !e.is_wr && e.access});
                    chk("sram_wr_used", {31'd0, wr_now}, {31'd0, e.is_wr});
                    chk("stall_cycles", stall_now, {24'd0, e.stall});
                end
                rd_now    = 1'b0;
                wr_now    = 1'b0;
                stall_now = 0;
            end
            saw_rd <= rd_now;
            saw_wr <= wr_now;
            stall  <= stall_now;
        end
    end

    // ---------------- stimulus ----------------
    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        bit   hit;
        int   cyc;
        sram_lat = $urandom_range(1, 4);
        if (wr) begin
            hit           = model_touch(a, 1'b0);
            ref_mem[a[11:2]] = d;
            x.is_wr       = 1'b1;
            x.access      = 1'b1;
            x.rdata       = 32'h0;
        end else begin
            hit      = model_touch(a, 1'b1);
            x.is_wr  = 1'b0;
            x.access = !hit;
            x.rdata  = ref_mem[a[11:2]];
        end
        x.stall = x.access ? 8'(sram_lat) : 8'd0;
        q.push_back(x);
        bus.mem_r_en = rd;
        bus.mem_w_en = wr;
        bus.address  = a;
        bus.wdata    = d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.ready && cyc < 60);
        if (!bus.ready) begin
            chk("request_timeout", 32'd0, 32'd1);
            finish_run();
        end
        @(posedge clk);
        #1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]  = (i * 32'h9E37_79B1) ^ 32'h1357_9BDF;
            sram_mem[i] = (i * 32'h9E37_79B1) ^ 32'h1357_9BDF;
        end
        ref_mem[10'h100]  = 32'hDEAD_BEEF;
        sram_mem[10'h100] = 32'hDEAD_BEEF;
        model_flush();
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.address  = 32'h0;
        bus.wdata    = 32'h0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'd0, bus.ready}, 32'd1);
        chk("reset_rdata", bus.rdata, 32'd0);
        chk("reset_sram_en", {30'd0, bus.sram_rd_en, bus.sram_wr_en}, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Miss fill then same-cycle hit.
        do_req(1, 0, 32'h400, 32'h0);
        do_req(1, 0, 32'h400, 32'h0);
        // Write miss does not allocate.
        do_req(0, 1, 32'h404, 32'h1234_5678);
        do_req(1, 0, 32'h404, 32'h0);
        // Write hit updates the cached line.
        do_req(0, 1, 32'h400, 32'hCAFE_F00D);
        do_req(1, 0, 32'h400, 32'h0);
        // Replacement order within set 0.
        do_req(1, 0, 32'h400, 32'h0);
        do_req(1, 0, 32'h500, 32'h0);
        do_req(1, 0, 32'h400, 32'h0);
        do_req(1, 0, 32'h600, 32'h0);
        do_req(1, 0, 32'h400, 32'h0);
        do_req(1, 0, 32'h500, 32'h0);
        // Simultaneous load and store behaves as a store.
        do_req(1, 1, 32'h408, 32'h0BAD_CAFE);

        // Reset in the middle of a read miss.
        sram_lat     = 8;
        bus.mem_r_en = 1'b1;
        bus.address  = 32'h7F0;
        @(negedge clk);
        @(negedge clk);
        chk("miss_rd_en", {31'd0, bus.sram_rd_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_rd_en", {31'd0, bus.sram_rd_en}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.sram_wr_en}, 32'd0);
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        model_flush();
        bus.mem_r_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        do_req(1, 0, 32'h400, 32'h0);

        // Random traffic over eight sets and four tags.
        for (int n = 0; n < 400; n++) begin
            a  = ({29'd0, 3'($urandom_range(0, 3))} << 8) |
                 ({29'd0, 3'($urandom_range(0, 7))} << 2) |
                 32'($urandom_range(0, 3));
            op = $urandom_range(0, 9);
            if (op < 6)       do_req(1, 0, a, 32'h0);
            else if (op < 9)  do_req(0, 1, a, $urandom);
            else              do_req(1, 1, a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 32'd0);
        finish_run();
    end
endmodule
